// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, S-box tables and GF(2^8) helpers
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_e;

  // Byte 0 sits in the most significant byte, matching the bus ordering
  typedef logic [0:15][7:0] block_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [0:255][7:0] t;
    t = {256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
         256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
         256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
         256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
         256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
         256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
         256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
         256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16};
    return t[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [0:255][7:0] t;
    t = {256'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb,
         256'h547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125,
         256'h72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84,
         256'h90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b,
         256'h3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e,
         256'h47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4,
         256'h1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef,
         256'ha0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d};
    return t[b];
  endfunction

endpackage

// File: rtl/decrypt_round.sv
// rtl/decrypt_round.sv - one combinational AES inverse round
module decrypt_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_last,
  output logic [127:0] o_state
);

  block_t w_st;
  block_t w_rk;
  block_t w_ark;
  block_t w_mix;

  always_comb begin
    w_st  = i_state;
    w_rk  = i_rk;
    w_ark = '0;
    w_mix = '0;
    // Row r rotates right by r: output column c takes input column c-r
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_ark[r + 4*c] = inv_sbox(w_st[r + 4*((c + 4 - r) % 4)]) ^ w_rk[r + 4*c];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mix[4*c]   = mul14(w_ark[4*c]) ^ mul11(w_ark[4*c+1]) ^ mul13(w_ark[4*c+2]) ^ mul9(w_ark[4*c+3]);
      w_mix[4*c+1] = mul9(w_ark[4*c])  ^ mul14(w_ark[4*c+1]) ^ mul11(w_ark[4*c+2]) ^ mul13(w_ark[4*c+3]);
      w_mix[4*c+2] = mul13(w_ark[4*c]) ^ mul9(w_ark[4*c+1])  ^ mul14(w_ark[4*c+2]) ^ mul11(w_ark[4*c+3]);
      w_mix[4*c+3] = mul11(w_ark[4*c]) ^ mul13(w_ark[4*c+1]) ^ mul9(w_ark[4*c+2])  ^ mul14(w_ark[4*c+3]);
    end
    o_state = i_last ? w_ark : w_mix;
  end

endmodule

// File: rtl/inv_cipher.sv
// rtl/inv_cipher.sv - iterative AES-128 decryption, one inverse round per clock
module inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [127:0]            in,
  input  logic [128*(NR+1)-1:0]   w,
  output logic [127:0]            out,
  output logic                    done,
  output logic                    busy
);

  if (NR != 10) begin : g_nr_illegal
    $error("inv_cipher supports only NR=10 (AES-128)");
  end

  state_e       r_fsm;
  state_e       w_fsm_nxt;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic [127:0] r_out;
  logic         r_done;
  logic         r_busy;
  logic [127:0] w_rk_sel;
  logic [127:0] w_round_out;

  // r_round is 0 in LAST, so the same select delivers rk0 for the final round
  always_comb w_rk_sel = w[128*(NR - int'(r_round)) +: 128];

  decrypt_round u_round (
    .i_state (r_state),
    .i_rk    (w_rk_sel),
    .i_last  (r_fsm == LAST),
    .o_state (w_round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (start) w_fsm_nxt = RUN;
      RUN:     if (r_round == 4'd1) w_fsm_nxt = LAST;
      LAST:    w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round <= '0;
      r_state <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: if (start) begin
          r_state <= in ^ w[127:0];
          r_round <= 4'(NR - 1);
          r_busy  <= 1'b1;
        end
        RUN: begin
          r_state <= w_round_out;
          r_round <= r_round - 4'd1;
        end
        LAST: begin
          r_out  <= w_round_out;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out  = r_out;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_inv_cipher.sv
// tb/tb_inv_cipher.sv - self-checking bench for inv_cipher against a behavioural AES model
module tb_inv_cipher;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  in_blk;
  logic [1407:0] w_bus;
  logic [127:0]  out_blk;
  logic          done;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  inv_cipher dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in_blk),
    .w     (w_bus),
    .out   (out_blk),
    .done  (done),
    .busy  (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   wd [44];
    logic [31:0]   tmp;
    logic [7:0]    rcon = 8'h01;
    logic [1407:0] res;
    for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = wd[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      wd[i] = wd[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = wd[i];
    return res;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1407:0] wb);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ wb[1407-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ wb[1407-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [127:0] ct);
    start = 1'b1;
    in_blk = ct;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 30);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_blk = '0; w_bus = '0;
    repeat (2) tick();
    checks++; if (out_blk !== 128'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", out_blk); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_kat_c1();
    w_bus = expand(C1_KEY);
    issue(C1_CT);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL c1_busy_edge0 got=%b exp=1", busy); end
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL c1_in_flight edge=%0d busy=%b done=%b exp busy=1 done=0", e, busy, done);
      end
    end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL c1_done_edge10 got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c1_busy_edge10 got=%b exp=0", busy); end
    checks++; if (out_blk !== C1_PT) begin failures++; $display("FAIL c1_out got=%h exp=%h", out_blk, C1_PT); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL c1_done_pulse got=%b exp=0", done); end
    checks++; if (out_blk !== C1_PT) begin failures++; $display("FAIL c1_out_hold got=%h exp=%h", out_blk, C1_PT); end
  endtask

  task automatic test_kat_b();
    int n;
    w_bus = expand(B_KEY);
    issue(B_CT);
    wait_done(n);
    checks++; if (n != 10) begin failures++; $display("FAIL b_latency got=%0d exp=10", n); end
    checks++; if (out_blk !== B_PT) begin failures++; $display("FAIL b_out got=%h exp=%h", out_blk, B_PT); end
  endtask

  task automatic test_back_to_back();
    int n;
    w_bus = expand(C1_KEY);
    issue(C1_CT);
    wait_done(n);
    checks++; if (n != 10 || out_blk !== C1_PT) begin
      failures++; $display("FAIL b2b_first lat=%0d out=%h exp lat=10 out=%h", n, out_blk, C1_PT);
    end
    w_bus = expand(B_KEY);
    issue(B_CT);
    for (int e = 0; e <= 9; e++) begin
      if (e > 0) tick();
      checks++;
      if (done !== 1'b0 || out_blk !== C1_PT) begin
        failures++; $display("FAIL b2b_hold edge=%0d done=%b out=%h exp done=0 out=%h", e, done, out_blk, C1_PT);
      end
    end
    tick();
    checks++; if (done !== 1'b1 || out_blk !== B_PT) begin
      failures++; $display("FAIL b2b_second done=%b out=%h exp done=1 out=%h", done, out_blk, B_PT);
    end
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    w_bus = expand(C1_KEY);
    issue(C1_CT);
    for (int e = 1; e <= 22; e++) begin
      start = (e == 3 || e == 7);
      in_blk = rnd128();
      tick();
      if (done) ndone++;
      if (e == 10) begin
        checks++; if (done !== 1'b1 || out_blk !== C1_PT) begin
          failures++; $display("FAIL busy_ignore_out done=%b out=%h exp done=1 out=%h", done, out_blk, C1_PT);
        end
      end
    end
    start = 1'b0;
    checks++; if (ndone != 1) begin failures++; $display("FAIL busy_ignore_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    int n;
    w_bus = expand(C1_KEY);
    issue(C1_CT);
    repeat (4) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_blk !== 128'h0) begin failures++; $display("FAIL arst_out got=%h exp=0", out_blk); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (done || busy) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL arst_quiet got=%0d exp=0", ndone); end
    w_bus = expand(B_KEY);
    issue(B_CT);
    wait_done(n);
    checks++; if (n != 10 || out_blk !== B_PT) begin
      failures++; $display("FAIL arst_recover lat=%0d out=%h exp lat=10 out=%h", n, out_blk, B_PT);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] key, pt, ct;
    int n;
    for (int it = 0; it < 200; it++) begin
      key = rnd128();
      pt  = rnd128();
      w_bus = expand(key);
      ct = enc(pt, w_bus);
      issue(ct);
      wait_done(n);
      checks++;
      if (n != 10 || out_blk !== pt) begin
        failures++; $display("FAIL round_trip it=%0d lat=%0d out=%h exp lat=10 out=%h", it, n, out_blk, pt);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat_c1();
    test_kat_b();
    test_back_to_back();
    test_start_while_busy();
    test_async_reset();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
